down_counter_load: RTL
======================

Name: down_counter_load

Overview:
- Loadable 8-bit down-counter/timer; the counting-down counterpart of the free-running up-counter (Counter8) that drives the icestick J3 header.
- Host loads a start value and the block decrements on each clock-enable.
- Pulses a terminal-count strobe on expiry.
- Either stops (one-shot) or reloads itself (periodic), giving tick/baud/blink timers for the icestick designs.

Parameters:
- WIDTH, 8, counter and load-value width in bits.
- RELOAD, 1, 1 = periodic (auto-reload on expiry); 0 = one-shot (stop at zero).

Ports:
- CLK  input  1  rising-edge clock.
- RESETN  input  1  asynchronous active-low reset.
- LOAD  input  1  synchronous load strobe, sampled on CLK rise.
- D  input  WIDTH  load value, sampled when LOAD=1.
- CE  input  1  count enable; one decrement per cycle with CE=1.
- O  output  WIDTH  current count (registered).
- TC  output  1  terminal-count pulse, exactly one cycle wide (registered).
- BUSY  output  1  1 while in RUN state (registered).

Behaviour:
- Interface: one clock, CLK. Reset is RESETN: asynchronous, active-low. Assertion clears all state immediately, independent of CLK.
- Internal state: count register CNT (drives O), reload register RLD, state bit {IDLE, RUN}, TC flop.
- Reset values: CNT=0, RLD=0, state=IDLE, O=0, TC=0, BUSY=0.
- Priority each cycle: RESETN > LOAD > CE.
- LOAD=1, D!=0:
  - RLD<=D, CNT<=D, state<=RUN, TC<=0.
  - BUSY=1 and O=D from the next cycle.
  - CE in the same cycle is ignored.
- LOAD=1, D==0: RLD<=0, CNT<=0, state<=IDLE, TC<=0. No expiry pulse.
- RUN, LOAD=0, CE=1, CNT>1: CNT<=CNT-1, TC<=0.
- RUN, LOAD=0, CE=1, CNT==1 (expiry): TC<=1.
  - RELOAD=1: CNT<=RLD, stay RUN.
  - RELOAD=0: CNT<=0, state<=IDLE, BUSY<=0.
- RUN, CE=0: CNT holds, TC<=0.
- IDLE, LOAD=0: CNT holds regardless of CE; TC<=0. No wrap from 0 to all-ones.
- TC is a registered pulse: high in the first cycle O shows the post-expiry value (RLD or 0), low next cycle unless expiry repeats.
- Periodic period = RLD CE-cycles. RLD=1 with RELOAD=1 and CE held high gives TC high every cycle and O stuck at 1.
- LOAD in the same cycle as an expiry condition: LOAD wins, TC stays 0, new value loaded.
- Arithmetic is unsigned modulo 2^WIDTH. CNT never decrements below 1 in RUN, so underflow cannot occur.
- Decrement: subtract constant 1 via a ripple chain (full adders with all-ones operand, or SB_CARRY borrow chain). The zero/one compare is combinational on CNT.
- Latency: LOAD to O valid is 1 cycle; expiry CE edge to TC high is 1 cycle.
- Reset mid-run: outputs go to reset values asynchronously. After RESETN deasserts, the block sits in IDLE until a LOAD.

Test Plan:
- Reset: RESETN=0 mid-count (O=0x23, BUSY=1) -> O=0x00, TC=0, BUSY=0 before the next CLK edge. Stays IDLE with CE=1 after release.
- One-shot (RELOAD=0): LOAD D=0x03, then CE=1 continuously.
  - O sequence: 3, 2, 1, 0; TC=1 only in the cycle O becomes 0.
  - BUSY drops with it; O stays 0 for 5 further cycles.
- Periodic (RELOAD=1): LOAD D=0x04, CE=1 continuously -> O: 4, 3, 2, 1, 4, 3, 2, 1, 4; TC high exactly on each return to 4 (every 4 cycles).
- Gated CE: LOAD D=0x02, CE pattern 1,0,0,1 -> O: 2, 1, 1, 1, then expiry. Single TC pulse. No decrement or TC while CE=0.
- Collisions:
  - LOAD D=0x10 asserted in the cycle CNT==1 with CE=1 -> O=0x10 next, TC stays 0.
  - LOAD D=0x00 -> IDLE, BUSY=0, no TC.
- Edge values: RELOAD=1, LOAD D=0x01, CE=1 -> O=1 constant, TC=1 every cycle. LOAD D=0xFF -> 255 CE-cycles to first TC.

Source files
------------

// File: rtl/down_counter_load.sv
// -----------------------------------------------------------------------------
// down_counter_load
//
// Loadable down-counter / timer. The host loads a start value with LOAD; the
// counter then decrements once per clock in which CE is high. When the count
// expires (a CE cycle with the count at 1), TC pulses for one cycle. In
// periodic mode (RELOAD=1) the counter reloads its start value and keeps
// running. In one-shot mode (RELOAD=0) it stops at zero and returns to IDLE.
//
// Parameters:
//   WIDTH  - counter and load-value width in bits
//   RELOAD - 1: periodic (auto-reload on expiry), 0: one-shot (stop at zero)
//
// Ports:
//   CLK    in   1      rising-edge clock
//   RESETN in   1      asynchronous active-low reset
//   LOAD   in   1      synchronous load strobe
//   D      in   WIDTH  load value, sampled when LOAD=1
//   CE     in   1      count enable, one decrement per CE cycle
//   O      out  WIDTH  current count (registered)
//   TC     out  1      terminal-count pulse, one cycle wide (registered)
//   BUSY   out  1      high while the counter is running (registered)
// -----------------------------------------------------------------------------
module down_counter_load #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          RELOAD = 1'b1
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             CE,
    output logic [WIDTH-1:0] O,
    output logic             TC,
    output logic             BUSY
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] rld;
    logic             tc_q;

    logic [WIDTH-1:0] cnt_dec;
    logic             dec_carry;
    logic             cnt_is_one;
    logic             load_nonzero;

    // Decrement as CNT + all-ones through a ripple of full adders. With the
    // second operand tied to 1, each stage reduces to sum = ~(a ^ c) and
    // carry = a | c. The final carry-out is not needed.
    always_comb begin
        cnt_dec   = '0;
        dec_carry = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_dec[i] = ~(cnt[i] ^ dec_carry);
            dec_carry  = cnt[i] | dec_carry;
        end
    end

    assign cnt_is_one   = (cnt == CNT_ONE);
    assign load_nonzero = (D != '0);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt   <= '0;
            rld   <= '0;
            state <= IDLE;
            tc_q  <= 1'b0;
        end else if (LOAD) begin
            // A load overrides any expiry in the same cycle. Loading zero
            // parks the counter in IDLE without a TC pulse.
            rld   <= D;
            cnt   <= D;
            state <= load_nonzero ? RUN : IDLE;
            tc_q  <= 1'b0;
        end else if ((state == RUN) && CE) begin
            if (cnt_is_one) begin
                tc_q <= 1'b1;
                if (RELOAD) begin
                    cnt <= rld;
                end else begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            end else begin
                cnt  <= cnt_dec;
                tc_q <= 1'b0;
            end
        end else begin
            // IDLE holds regardless of CE (no wrap from zero); RUN with CE=0
            // holds the count.
            tc_q <= 1'b0;
        end
    end

    assign O    = cnt;
    assign TC   = tc_q;
    assign BUSY = (state == RUN);

endmodule
